// File: rtl/fmrv32im_div_pkg.sv
// fmrv32im_div_pkg: shared types and constants for the RV32M divide unit.
//   - div_state_e : FSM encoding (IDLE / EXEC / FINISH)
//   - constants for the divide-by-zero quotient, the overflow dividend and
//     the iteration count, plus a two's-complement negate helper.
package fmrv32im_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE       = 32'hFFFF_FFFF;
  localparam logic [4:0]  ITER_CNT      = 5'd31;

  // Two's-complement negate on 32 bits.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/fmrv32im_div_if.sv
// fmrv32im_div_if: execute-stage operand/result bundle shared with the
// multiplier.
//   master (pipeline): drives INST_DIV/DIVU/REM/REMU, RS1, RS2;
//                      receives WAIT, READY, RD.
//   slave  (divider) : the mirror image.
interface fmrv32im_div_if;
  logic        INST_DIV;
  logic        INST_DIVU;
  logic        INST_REM;
  logic        INST_REMU;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic        WAIT;
  logic        READY;
  logic [31:0] RD;

  modport master (
    output INST_DIV, INST_DIVU, INST_REM, INST_REMU, RS1, RS2,
    input  WAIT, READY, RD
  );

  modport slave (
    input  INST_DIV, INST_DIVU, INST_REM, INST_REMU, RS1, RS2,
    output WAIT, READY, RD
  );
endinterface

// File: rtl/fmrv32im_div_step.sv
// fmrv32im_div_step: one combinational restoring-division step.
//   rem_i[32:0], quo_i[31:0] : current partial remainder / quotient-dividend
//   div_i[31:0]              : divisor magnitude
//   rem_o, quo_o             : values after shifting {rem,quo} left by one and
//                              subtracting the divisor when it fits.
module fmrv32im_div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [33:0] shifted_s;
  logic [33:0] trial_s;

  // Shift in the next dividend bit and try the subtraction; bit 33 of the
  // trial is its sign.
  always_comb begin
    shifted_s = {rem_i, quo_i[31]};
    trial_s   = shifted_s - {2'b00, div_i};
    if (!trial_s[33]) begin
      rem_o = trial_s[32:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted_s[32:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/fmrv32im_div.sv
// fmrv32im_div: iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per
// clock (restoring). Ports:
//   CLK, RST_N : clock and asynchronous active-low reset
//   bus        : fmrv32im_div_if.slave (INST_*, RS1, RS2 in; WAIT, READY, RD out)
// Divide-by-zero and signed overflow bypass the iteration and finish in one
// cycle. WAIT is combinational so the pipeline stalls in the request cycle.
module fmrv32im_div
  import fmrv32im_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           CLK,
  input  logic           RST_N,
  fmrv32im_div_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [32:0]      rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             rem_op_q, rem_op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ready_q, ready_d;
  logic [XLEN-1:0]  rd_q, rd_d;

  logic             start_s, op_signed_s, op_rem_s, div0_s, ovf_s, wait_s;
  logic [31:0]      a_abs_s, b_abs_s, fast_res_s, final_s;
  logic [32:0]      step_rem_s;
  logic [31:0]      step_quo_s;

  fmrv32im_div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Request decode: DIV > DIVU > REM > REMU when several are raised.
  always_comb begin
    start_s = bus.INST_DIV | bus.INST_DIVU | bus.INST_REM | bus.INST_REMU;
    if (bus.INST_DIV) begin
      op_signed_s = 1'b1;
      op_rem_s    = 1'b0;
    end else if (bus.INST_DIVU) begin
      op_signed_s = 1'b0;
      op_rem_s    = 1'b0;
    end else if (bus.INST_REM) begin
      op_signed_s = 1'b1;
      op_rem_s    = 1'b1;
    end else begin
      op_signed_s = 1'b0;
      op_rem_s    = 1'b1;
    end
    div0_s = (bus.RS2 == 32'd0);
    ovf_s  = op_signed_s && (bus.RS1 == INT_MIN) && (bus.RS2 == NEG_ONE);
    a_abs_s = (op_signed_s && bus.RS1[31]) ? neg32(bus.RS1) : bus.RS1;
    b_abs_s = (op_signed_s && bus.RS2[31]) ? neg32(bus.RS2) : bus.RS2;
    // Fast-path result; only consumed when div0_s or ovf_s is set.
    if (div0_s) begin
      fast_res_s = op_rem_s ? bus.RS1 : DIV0_QUOTIENT;
    end else begin
      fast_res_s = op_rem_s ? 32'd0 : INT_MIN;
    end
  end

  // Sign fix-up of the last step's output, used on the final EXEC cycle.
  always_comb begin
    if (rem_op_q) begin
      final_s = neg_rem_q ? neg32(step_rem_s[31:0]) : step_rem_s[31:0];
    end else begin
      final_s = neg_quo_q ? neg32(step_quo_s) : step_quo_s;
    end
  end

  // Next-state logic; FINISH accepts a new request exactly like IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    rd_d      = rd_q;
    case (state_q)
      IDLE, FINISH: begin
        if (start_s) begin
          rem_op_d  = op_rem_s;
          neg_quo_d = op_signed_s & (bus.RS1[31] ^ bus.RS2[31]);
          neg_rem_d = op_signed_s & bus.RS1[31];
          if (div0_s || ovf_s) begin
            state_d = FINISH;
            rd_d    = fast_res_s;
            ready_d = 1'b1;
          end else begin
            state_d = EXEC;
            quo_d   = a_abs_s;
            dvs_d   = b_abs_s;
            rem_d   = 33'd0;
            cnt_d   = ITER_CNT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // New requests are ignored here; the pipeline is stalled by WAIT.
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        if (cnt_q == 5'd0) begin
          state_d = FINISH;
          rd_d    = final_s;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      rem_q     <= 33'd0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      rd_q      <= rd_d;
    end
  end

  // Stall while busy, and in the request cycle itself.
  always_comb begin
    wait_s = (((state_q == IDLE) || (state_q == FINISH)) && start_s) ||
             (state_q == EXEC);
  end

  assign bus.WAIT  = wait_s;
  assign bus.READY = ready_q;
  assign bus.RD    = rd_q;

endmodule

// File: tb/tb_fmrv32im_div.sv
// tb_fmrv32im_div: scoreboard bench for fmrv32im_div. Each request pushes its
// expected result and completion cycle; a monitor pops on every READY.
module tb_fmrv32im_div;

  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_REM  = 2;
  localparam int OP_REMU = 3;

  typedef struct {
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t sb[$];

  fmrv32im_div_if bus ();

  fmrv32im_div #(.XLEN(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Independent reference using SV arithmetic (truncating division).
  function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic rem;
    sgn = (op == OP_DIV) || (op == OP_REM);
    rem = (op == OP_REM) || (op == OP_REMU);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic bit is_fast(input int op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ||
           (((op == OP_DIV) || (op == OP_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic clear_inputs();
    bus.INST_DIV  = 1'b0;
    bus.INST_DIVU = 1'b0;
    bus.INST_REM  = 1'b0;
    bus.INST_REMU = 1'b0;
    bus.RS1       = 32'd0;
    bus.RS2       = 32'd0;
  endtask

  // Call just after a negedge: drives a request for this cycle.
  task automatic start_op(input int op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.INST_DIV  = (op == OP_DIV);
    bus.INST_DIVU = (op == OP_DIVU);
    bus.INST_REM  = (op == OP_REM);
    bus.INST_REMU = (op == OP_REMU);
    bus.RS1 = a;
    bus.RS2 = b;
    e.rd  = ref_res(op, a, b);
    e.cyc = cyc + (is_fast(op, a, b) ? 1 : 33);
    sb.push_back(e);
    #1;
    check("wait_req", {31'd0, bus.WAIT}, 32'd1);
  endtask

  // Runs until READY; WAIT must stay high before it and drop with it.
  task automatic finish_op();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      clear_inputs();
      #1;
      if (bus.READY) seen = 1'b1;
      else check("wait_busy", {31'd0, bus.WAIT}, 32'd1);
      n++;
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    else check("wait_fin", {31'd0, bus.WAIT}, 32'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && bus.READY) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd", bus.RD, e.rd);
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int op;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("rst_wait", {31'd0, bus.WAIT}, 32'd0);
    check("rst_ready", {31'd0, bus.READY}, 32'd0);
    check("rst_rd", bus.RD, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(OP_DIVU, 32'd100, 32'd7);            finish_op();
    start_op(OP_REMU, 32'd100, 32'd7);            finish_op();
    start_op(OP_DIV,  32'hFFFF_FFF9, 32'd2);      finish_op();
    start_op(OP_REM,  32'hFFFF_FFF9, 32'd2);      finish_op();
    start_op(OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE); finish_op();
    start_op(OP_DIVU, 32'h1234_5678, 32'd0);      finish_op();
    start_op(OP_REMU, 32'h1234_5678, 32'd0);      finish_op();
    start_op(OP_DIV,  32'hFFFF_FFFB, 32'd0);      finish_op();
    start_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF); finish_op();
    start_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF); finish_op();

    // Back-to-back: second request issued in the first one's FINISH cycle.
    start_op(OP_DIVU, 32'd10, 32'd3);
    finish_op();
    start_op(OP_REMU, 32'd10, 32'd3);
    finish_op();

    // Spurious INST_DIV while busy must not disturb the running result.
    start_op(OP_DIVU, 32'd1000, 32'd10);
    repeat (5) begin
      @(negedge clk);
      clear_inputs();
    end
    bus.INST_DIV = 1'b1;
    bus.RS1 = 32'd77;
    bus.RS2 = 32'd0;
    finish_op();

    // A few random operations, one per opcode at least.
    for (int i = 0; i < 8; i++) begin
      op = i % 4;
      a = $urandom();
      b = (i == 5) ? 32'd0 : ($urandom() >> (i * 3));
      start_op(op, a, b);
      finish_op();
    end

    // Asynchronous reset in cycle T+10 of a DIVU, away from any edge.
    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (10) begin
      @(negedge clk);
      clear_inputs();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wait", {31'd0, bus.WAIT}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.READY}, 32'd0);
    check("mid_rst_rd", bus.RD, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("mid_rst_hold_ready", {31'd0, bus.READY}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    finish_op();

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
